// File: rtl/riscv_rf_pkg.sv
// Shared types and helpers for the scoreboarded register file.
package riscv_rf_pkg;

  localparam int unsigned RF_CNT_WIDTH = 2;

  typedef logic [RF_CNT_WIDTH-1:0] rf_cnt_t;

  // Saturation value of an outstanding-write counter of the given width.
  function automatic int unsigned rf_cnt_max(input int unsigned cnt_width);
    return (32'd1 << cnt_width) - 32'd1;
  endfunction

  // An address maps to real storage unless out of range or the hardwired zero.
  function automatic logic rf_addr_live(input int unsigned addr,
                                        input int unsigned num_words,
                                        input logic        zero_reg);
    return (addr < num_words) && !(zero_reg && (addr == 32'd0));
  endfunction

endpackage

// File: rtl/riscv_rf_scoreboard.sv
// Per-register outstanding-writeback counters with reservation handshake and sticky error.
module riscv_rf_scoreboard
  import riscv_rf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_WORDS  = 2**ADDR_WIDTH,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned CNT_WIDTH  = RF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rsv_valid,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  output logic                  rsv_ready,
  input  logic                  rel_valid,
  input  logic [ADDR_WIDTH-1:0] rel_addr,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  input  logic [ADDR_WIDTH-1:0] raddr_c,
  output logic                  busy_a,
  output logic                  busy_b,
  output logic                  busy_c,
  output logic                  err
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam cnt_t CNT_MAX = CNT_WIDTH'(rf_cnt_max(CNT_WIDTH));
  localparam logic ZR      = (ZERO_REG != 0);

  cnt_t cnt_q [NUM_WORDS];
  cnt_t cnt_d [NUM_WORDS];
  logic err_q;
  logic err_set;
  logic rsv_acc;
  logic rel_live;

  function automatic logic live(input logic [ADDR_WIDTH-1:0] a);
    return rf_addr_live(32'(a), NUM_WORDS, ZR);
  endfunction

  function automatic cnt_t cnt_of(input logic [ADDR_WIDTH-1:0] a);
    return live(a) ? cnt_q[a] : '0;
  endfunction

  function automatic logic rel_hit(input logic [ADDR_WIDTH-1:0] a);
    return rel_valid && (rel_addr == a);
  endfunction

  // With bypass, a release landing this cycle already hides its last pending entry.
  function automatic logic busy_of(input logic [ADDR_WIDTH-1:0] a);
    return (cnt_of(a) != '0) &&
           !((BYPASS != 0) && rel_hit(a) && (cnt_of(a) == CNT_WIDTH'(1)));
  endfunction

  always_comb begin
    rsv_ready = !live(rsv_addr) || (cnt_of(rsv_addr) != CNT_MAX) || rel_hit(rsv_addr);
    busy_a    = busy_of(raddr_a);
    busy_b    = busy_of(raddr_b);
    busy_c    = busy_of(raddr_c);
    rsv_acc   = rsv_valid && rsv_ready && live(rsv_addr);
    rel_live  = rel_valid && live(rel_addr);
    err_set   = (rsv_valid && !rsv_ready) || (rel_live && (cnt_of(rel_addr) == '0));
    for (int r = 0; r < int'(NUM_WORDS); r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else if (rsv_acc && (rsv_addr == ADDR_WIDTH'(r)) &&
                   !(rel_live && (rel_addr == ADDR_WIDTH'(r)))) begin
        cnt_d[r] = cnt_q[r] + CNT_WIDTH'(1);
      end else if (rel_live && (rel_addr == ADDR_WIDTH'(r)) &&
                   !(rsv_acc && (rsv_addr == ADDR_WIDTH'(r))) && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(NUM_WORDS); r++) cnt_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < int'(NUM_WORDS); r++) cnt_q[r] <= cnt_d[r];
      err_q <= err_q | err_set;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/riscv_register_file_sb.sv
// 3R/2W flop register file with optional write bypass and an integrated writeback scoreboard.
module riscv_register_file_sb
  import riscv_rf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 2**ADDR_WIDTH,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned CNT_WIDTH  = RF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_c_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  output logic [DATA_WIDTH-1:0] rdata_b_o,
  output logic [DATA_WIDTH-1:0] rdata_c_o,
  output logic                  rbusy_a_o,
  output logic                  rbusy_b_o,
  output logic                  rbusy_c_o,
  input  logic [ADDR_WIDTH-1:0] waddr_a_i,
  input  logic [DATA_WIDTH-1:0] wdata_a_i,
  input  logic                  we_a_i,
  input  logic [ADDR_WIDTH-1:0] waddr_b_i,
  input  logic [DATA_WIDTH-1:0] wdata_b_i,
  input  logic                  we_b_i,
  input  logic                  rsv_valid_i,
  input  logic [ADDR_WIDTH-1:0] rsv_addr_i,
  output logic                  rsv_ready_o,
  input  logic                  flush_i,
  output logic                  err_o
);

  localparam logic ZR = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  function automatic logic live(input logic [ADDR_WIDTH-1:0] a);
    return rf_addr_live(32'(a), NUM_WORDS, ZR);
  endfunction

  // Port B is evaluated last so it wins a same-address collision in the bypass too.
  function automatic logic [DATA_WIDTH-1:0] read_word(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    if (rst_n && live(a)) begin
      d = mem[a];
      if (BYPASS != 0) begin
        if (we_a_i && (waddr_a_i == a)) d = wdata_a_i;
        if (we_b_i && (waddr_b_i == a)) d = wdata_b_i;
      end
    end
    return d;
  endfunction

  always_comb begin
    rdata_a_o = read_word(raddr_a_i);
    rdata_b_o = read_word(raddr_b_i);
    rdata_c_o = read_word(raddr_c_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(NUM_WORDS); r++) mem[r] <= '0;
    end else begin
      if (we_a_i && live(waddr_a_i)) mem[waddr_a_i] <= wdata_a_i;
      if (we_b_i && live(waddr_b_i)) mem[waddr_b_i] <= wdata_b_i;
    end
  end

  riscv_rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WORDS  (NUM_WORDS),
    .ZERO_REG   (ZERO_REG),
    .BYPASS     (BYPASS),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .rsv_valid (rsv_valid_i),
    .rsv_addr  (rsv_addr_i),
    .rsv_ready (rsv_ready_o),
    .rel_valid (we_b_i),
    .rel_addr  (waddr_b_i),
    .flush     (flush_i),
    .raddr_a   (raddr_a_i),
    .raddr_b   (raddr_b_i),
    .raddr_c   (raddr_c_i),
    .busy_a    (rbusy_a_o),
    .busy_b    (rbusy_b_o),
    .busy_c    (rbusy_c_o),
    .err       (err_o)
  );

endmodule

// File: tb/tb_riscv_register_file_sb.sv
// Bench for riscv_register_file_sb: directed scenarios plus randomized traffic against a behavioural model.
module tb_riscv_register_file_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  raddr_a, raddr_b, raddr_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        rbusy_a, rbusy_b, rbusy_c;
  logic [4:0]  waddr_a, waddr_b, rsv_addr;
  logic [31:0] wdata_a, wdata_b;
  logic        we_a, we_b, rsv_valid, rsv_ready, flush, err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mmem [32];
  int          mcnt [32];
  logic        merr;

  always #5 clk = ~clk;

  riscv_register_file_sb dut (
    .clk(clk), .rst_n(rst_n),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .raddr_c_i(raddr_c),
    .rdata_a_o(rdata_a), .rdata_b_o(rdata_b), .rdata_c_o(rdata_c),
    .rbusy_a_o(rbusy_a), .rbusy_b_o(rbusy_b), .rbusy_c_o(rbusy_c),
    .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
    .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .rsv_ready_o(rsv_ready),
    .flush_i(flush), .err_o(err)
  );

  function automatic logic [31:0] exp_rdata(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 32'd0;
    if (we_b && waddr_b == a) return wdata_b;
    if (we_a && waddr_a == a) return wdata_a;
    return mmem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    int pend;
    if (!rst_n || a == 5'd0) return 1'b0;
    pend = mcnt[a] - ((we_b && waddr_b == a) ? 1 : 0);
    return pend > 0;
  endfunction

  function automatic logic exp_ready();
    if (rsv_addr == 5'd0) return 1'b1;
    return (mcnt[rsv_addr] < 3) || (we_b && waddr_b == rsv_addr);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mmem[i] = 32'd0;
      mcnt[i] = 0;
    end
    merr = 1'b0;
  endtask

  task automatic idle();
    we_a = 1'b0; we_b = 1'b0; rsv_valid = 1'b0; flush = 1'b0;
    waddr_a = 5'd0; waddr_b = 5'd0; rsv_addr = 5'd0;
    wdata_a = 32'd0; wdata_b = 32'd0;
  endtask

  // Advance one clock edge, applying the architectural rules to the model.
  task automatic tick();
    logic [31:0] nm [32];
    int          nc [32];
    logic        ne;
    logic        rdy;
    int          delta;
    nm = mmem; nc = mcnt; ne = merr; rdy = exp_ready();
    if (we_a && waddr_a != 5'd0) nm[waddr_a] = wdata_a;
    if (we_b && waddr_b != 5'd0) nm[waddr_b] = wdata_b;
    if (rsv_valid && !rdy) ne = 1'b1;
    if (we_b && waddr_b != 5'd0 && mcnt[waddr_b] == 0) ne = 1'b1;
    for (int i = 1; i < 32; i++) begin
      delta = ((rsv_valid && rdy && rsv_addr == 5'(i)) ? 1 : 0) - ((we_b && waddr_b == 5'(i)) ? 1 : 0);
      nc[i] = flush ? 0 : ((mcnt[i] + delta < 0) ? 0 : mcnt[i] + delta);
    end
    @(posedge clk);
    if (rst_n) begin
      mmem = nm; mcnt = nc; merr = ne;
    end else begin
      model_clear();
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    model_clear();
    we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hA5A5_A5A5;
    raddr_a = 5'd5; raddr_b = 5'd0; raddr_c = 5'd1; rsv_addr = 5'd3;
    @(negedge clk); #1;
    n_checks++; if (rdata_a !== 32'd0) begin n_errors++; $display("FAIL reset_rdata: got %h want 0", rdata_a); end
    n_checks++; if (rbusy_a !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", rbusy_a); end
    n_checks++; if (rsv_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", rsv_ready); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", err); end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    idle(); we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hDEAD_BEEF;
    tick();
    idle(); raddr_a = 5'd5; #1;
    n_checks++; if (rdata_a !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL write_x5: got %h want deadbeef", rdata_a); end
    we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'hFFFF_FFFF; raddr_b = 5'd0; #1;
    n_checks++; if (rdata_b !== 32'd0) begin n_errors++; $display("FAIL x0_bypass: got %h want 0", rdata_b); end
    tick();
    idle(); #1;
    n_checks++; if (rdata_b !== 32'd0) begin n_errors++; $display("FAIL x0_stored: got %h want 0", rdata_b); end
  endtask

  task automatic test_write_priority();
    idle(); rsv_valid = 1'b1; rsv_addr = 5'd7;
    tick();
    idle();
    we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h11;
    we_b = 1'b1; waddr_b = 5'd7; wdata_b = 32'h22;
    raddr_a = 5'd7; #1;
    n_checks++; if (rdata_a !== 32'h22) begin n_errors++; $display("FAIL prio_bypass: got %h want 22", rdata_a); end
    n_checks++; if (rbusy_a !== 1'b0) begin n_errors++; $display("FAIL prio_busy: got %b want 0", rbusy_a); end
    tick();
    idle(); #1;
    n_checks++; if (rdata_a !== 32'h22) begin n_errors++; $display("FAIL prio_stored: got %h want 22", rdata_a); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL prio_err: got %b want 0", err); end
  endtask

  task automatic test_same_cycle_rsv_rel();
    idle(); rsv_valid = 1'b1; rsv_addr = 5'd9;
    tick();
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    we_b = 1'b1; waddr_b = 5'd9; wdata_b = 32'h99; raddr_a = 5'd9; #1;
    n_checks++; if (rsv_ready !== 1'b1) begin n_errors++; $display("FAIL x9_ready: got %b want 1", rsv_ready); end
    tick();
    idle(); raddr_a = 5'd9; #1;
    n_checks++; if (rbusy_a !== 1'b1) begin n_errors++; $display("FAIL x9_still_busy: got %b want 1", rbusy_a); end
    we_b = 1'b1; waddr_b = 5'd9; wdata_b = 32'h9A; #1;
    n_checks++; if (rbusy_a !== 1'b0) begin n_errors++; $display("FAIL x9_release_bypass: got %b want 0", rbusy_a); end
    tick();
    idle(); raddr_a = 5'd9; #1;
    n_checks++; if (rbusy_a !== 1'b0) begin n_errors++; $display("FAIL x9_idle: got %b want 0", rbusy_a); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL x9_err: got %b want 0", err); end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 3; k++) begin
      idle(); rsv_valid = 1'b1; rsv_addr = 5'd3;
      tick();
    end
    idle(); rsv_addr = 5'd3; raddr_a = 5'd3; #1;
    n_checks++; if (rbusy_a !== 1'b1) begin n_errors++; $display("FAIL sat_busy: got %b want 1", rbusy_a); end
    n_checks++; if (rsv_ready !== 1'b0) begin n_errors++; $display("FAIL sat_ready: got %b want 0", rsv_ready); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL sat_err_pre: got %b want 0", err); end
    rsv_valid = 1'b1;
    tick();
    rsv_valid = 1'b0; #1;
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL sat_err_post: got %b want 1", err); end
    n_checks++; if (rsv_ready !== 1'b0) begin n_errors++; $display("FAIL sat_still_full: got %b want 0", rsv_ready); end
    for (int k = 0; k < 3; k++) begin
      we_b = 1'b1; waddr_b = 5'd3; wdata_b = 32'(k); #1;
      n_checks++;
      if (rbusy_a !== (k < 2)) begin n_errors++; $display("FAIL sat_drain%0d: got %b want %b", k, rbusy_a, (k < 2)); end
      tick();
    end
    idle(); raddr_a = 5'd3; rsv_addr = 5'd3; #1;
    n_checks++; if (rbusy_a !== 1'b0 || rsv_ready !== 1'b1) begin n_errors++; $display("FAIL sat_empty: busy %b ready %b want 0 1", rbusy_a, rsv_ready); end
  endtask

  task automatic test_release_at_zero();
    idle(); apply_reset();
    we_b = 1'b1; waddr_b = 5'd4; wdata_b = 32'h44; raddr_b = 5'd4; #1;
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rz_err_pre: got %b want 0", err); end
    tick();
    idle(); raddr_b = 5'd4; #1;
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL rz_err: got %b want 1", err); end
    n_checks++; if (rdata_b !== 32'h44) begin n_errors++; $display("FAIL rz_data: got %h want 44", rdata_b); end
    tick(); #1;
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL rz_sticky: got %b want 1", err); end
  endtask

  task automatic test_flush();
    idle(); rsv_valid = 1'b1; rsv_addr = 5'd2; tick();
    idle(); rsv_valid = 1'b1; rsv_addr = 5'd6; tick();
    idle(); raddr_a = 5'd2; raddr_b = 5'd6; raddr_c = 5'd8; #1;
    n_checks++; if (rbusy_a !== 1'b1 || rbusy_b !== 1'b1) begin n_errors++; $display("FAIL fl_pre: busy %b %b want 1 1", rbusy_a, rbusy_b); end
    flush = 1'b1; rsv_valid = 1'b1; rsv_addr = 5'd8;
    tick();
    idle(); #1;
    n_checks++;
    if ({rbusy_a, rbusy_b, rbusy_c} !== 3'b000) begin n_errors++; $display("FAIL fl_post: busy %b%b%b want 000", rbusy_a, rbusy_b, rbusy_c); end
  endtask

  function automatic logic [4:0] rand_addr();
    return ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        model_clear();
      end else begin
        rst_n = 1'b1;
      end
      we_a = 1'($urandom_range(0, 1)); waddr_a = rand_addr(); wdata_a = $urandom;
      we_b = ($urandom_range(0, 9) < 3); waddr_b = rand_addr(); wdata_b = $urandom;
      rsv_valid = ($urandom_range(0, 9) < 4); rsv_addr = rand_addr();
      flush = ($urandom_range(0, 39) == 0);
      raddr_a = rand_addr(); raddr_b = rand_addr(); raddr_c = rand_addr();
      #1;
      n_checks++;
      if ({rdata_a, rdata_b, rdata_c} !== {exp_rdata(raddr_a), exp_rdata(raddr_b), exp_rdata(raddr_c)}) begin
        n_errors++;
        $display("FAIL rnd_rdata cyc %0d: got %h %h %h want %h %h %h", n, rdata_a, rdata_b, rdata_c,
                 exp_rdata(raddr_a), exp_rdata(raddr_b), exp_rdata(raddr_c));
      end
      n_checks++;
      if ({rbusy_a, rbusy_b, rbusy_c} !== {exp_busy(raddr_a), exp_busy(raddr_b), exp_busy(raddr_c)}) begin
        n_errors++;
        $display("FAIL rnd_busy cyc %0d: got %b%b%b want %b%b%b", n, rbusy_a, rbusy_b, rbusy_c,
                 exp_busy(raddr_a), exp_busy(raddr_b), exp_busy(raddr_c));
      end
      n_checks++;
      if (rsv_ready !== (!rst_n || exp_ready())) begin
        n_errors++; $display("FAIL rnd_ready cyc %0d: got %b want %b", n, rsv_ready, (!rst_n || exp_ready()));
      end
      n_checks++;
      if (err !== merr) begin n_errors++; $display("FAIL rnd_err cyc %0d: got %b want %b", n, err, merr); end
      tick();
    end
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_reset_midcycle();
    idle(); we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'h1234_5678; tick();
    idle(); rsv_valid = 1'b1; rsv_addr = 5'd5; tick();
    idle(); we_b = 1'b1; waddr_b = 5'd0; tick();
    idle(); raddr_a = 5'd5; rsv_addr = 5'd5; #1;
    n_checks++; if (rdata_a !== 32'h1234_5678 || rbusy_a !== 1'b1) begin n_errors++; $display("FAIL mid_pre: data %h busy %b want 12345678 1", rdata_a, rbusy_a); end
    #1 rst_n = 1'b0;
    model_clear();
    #1;
    n_checks++; if (rdata_a !== 32'd0) begin n_errors++; $display("FAIL mid_rdata: got %h want 0", rdata_a); end
    n_checks++; if (err !== 1'b0 || rbusy_a !== 1'b0 || rsv_ready !== 1'b1) begin n_errors++; $display("FAIL mid_state: err %b busy %b ready %b want 0 0 1", err, rbusy_a, rsv_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    raddr_a = 5'd0; raddr_b = 5'd0; raddr_c = 5'd0;
    idle();
    model_clear();
    test_reset();
    test_write_read();
    test_write_priority();
    test_same_cycle_rsv_rel();
    test_saturate();
    test_release_at_zero();
    test_flush();
    test_random();
    test_reset_midcycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
